// File: rtl/router_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : router_reg
//  Description : Byte-path register block of a packet router. It captures the
//                header, forwards header/payload/parity bytes to the selected
//                output FIFO, parks the byte that arrives while the FIFO is
//                full, and checks packet parity.
//
//  Ports       : clk            rising-edge clock
//                rst            synchronous reset, active-low
//                pkt_valid      source byte valid (low on the parity byte)
//                data_in[7:0]   source byte: header, payload or parity
//                fifo_full      full flag of the selected output FIFO
//                detect_add     controller state DECODE_ADDRESS
//                lfd_state      controller state LOAD_FIRST_DATA
//                ld_state       controller state LOAD_DATA
//                laf_state      controller state LOAD_AFTER_FULL
//                full_state     controller state FIFO_FULL_STATE
//                rst_int_reg    controller request to clear low_pkt_valid
//                dout[7:0]      byte presented to the FIFO write data
//                parity_done    parity byte received and captured
//                low_pkt_valid  pkt_valid fell during LOAD_DATA
//                err            parity mismatch for the completed packet
//
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module router_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    input  logic       detect_add,
    input  logic       lfd_state,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    input  logic       rst_int_reg,
    output logic [7:0] dout,
    output logic       parity_done,
    output logic       low_pkt_valid,
    output logic       err
);

    // Address value 3 does not correspond to any output port.
    localparam logic [1:0] c_BAD_ADDR = 2'b11;

    logic [7:0] r_hdr_byte;    // header of the packet in flight
    logic [7:0] r_full_byte;   // byte parked while the FIFO was full
    logic [7:0] r_int_parity;  // running XOR of header and payload
    logic [7:0] r_pkt_parity;  // parity byte sent by the source

    // Conditions shared by several registers.
    logic w_hdr_capture;
    logic w_ld_write;
    logic w_ld_park;
    logic w_ld_parity;
    logic w_laf_parity;

    assign w_hdr_capture = detect_add && pkt_valid && (data_in[1:0] != c_BAD_ADDR);
    assign w_ld_write    = ld_state && !fifo_full;
    assign w_ld_park     = ld_state && fifo_full;
    // Parity byte arrives in LOAD_DATA with room in the FIFO.
    assign w_ld_parity   = ld_state && !pkt_valid && !fifo_full;
    // Parity byte was parked in r_full_byte and is replayed once in LOAD_AFTER_FULL.
    assign w_laf_parity  = laf_state && low_pkt_valid && !parity_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout          <= 8'h00;
            r_hdr_byte    <= 8'h00;
            r_full_byte   <= 8'h00;
            r_int_parity  <= 8'h00;
            r_pkt_parity  <= 8'h00;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Header capture; an unroutable address leaves the old header.
            if (w_hdr_capture) begin
                r_hdr_byte <= data_in;
            end

            // FIFO data path. State inputs lead by one cycle, so the header
            // lands on dout the cycle after lfd_state.
            if (lfd_state) begin
                dout <= r_hdr_byte;
            end else if (w_ld_write) begin
                dout <= data_in;
            end else if (laf_state) begin
                dout <= r_full_byte;
            end

            // Park the byte that could not be written; it is replayed from
            // here in LOAD_AFTER_FULL so nothing is lost or duplicated.
            if (w_ld_park) begin
                r_full_byte <= data_in;
            end

            if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end else if (ld_state && !pkt_valid) begin
                low_pkt_valid <= 1'b1;
            end

            if (detect_add) begin
                parity_done <= 1'b0;
            end else if (w_ld_parity || w_laf_parity) begin
                parity_done <= 1'b1;
            end

            // A payload byte seen with fifo_full high is still accumulated
            // here: it is parked and written exactly once later, while the
            // FIFO_FULL_STATE repeat of the same byte is excluded.
            if (detect_add) begin
                r_int_parity <= 8'h00;
            end else if (lfd_state) begin
                r_int_parity <= r_int_parity ^ r_hdr_byte;
            end else if (ld_state && pkt_valid && !full_state) begin
                r_int_parity <= r_int_parity ^ data_in;
            end

            if (detect_add) begin
                r_pkt_parity <= 8'h00;
            end else if (w_ld_parity) begin
                r_pkt_parity <= data_in;
            end else if (w_laf_parity) begin
                r_pkt_parity <= r_full_byte;
            end

            // Compared one cycle after parity_done rises, when both parity
            // registers hold their final values.
            if (detect_add) begin
                err <= 1'b0;
            end else if (parity_done) begin
                err <= (r_int_parity != r_pkt_parity);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_router_reg
//  Description : Directed self-checking bench for router_reg. Each step
//                drives the controller state and source byte, pushes the
//                expected dout to a scoreboard queue, then pops and compares
//                it after the clock edge. Flag outputs are checked inline.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_router_reg;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int         n_cmp;
    int         n_bad;
    int         step_no;
    logic [7:0] exp_q[$];

    router_reg dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s (step %0d): observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    // Drive one cycle of controller state and source byte; the expected dout
    // goes into the scoreboard and is compared once the edge has passed.
    task automatic step(input logic da, input logic lfd, input logic ld,
                        input logic laf, input logic fs, input logic ff,
                        input logic pv, input logic [7:0] d, input logic rir,
                        input logic [7:0] exp_dout);
        logic [7:0] e;
        detect_add  = da;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fs;
        fifo_full   = ff;
        pkt_valid   = pv;
        data_in     = d;
        rst_int_reg = rir;
        exp_q.push_back(exp_dout);
        @(posedge clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        chk("dout", dout, e);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        step_no = 0;
        rst = 1'b1;
        {pkt_valid, fifo_full, detect_add, lfd_state, ld_state} = '0;
        {laf_state, full_state, rst_int_reg} = '0;
        data_in = 8'h00;

        // Reset overrides active inputs.
        rst = 1'b0;
        step(1,0,0,0,0,0,1,8'hAA,0, 8'h00);
        chk("rst_parity_done", {7'd0, parity_done},   8'd0);
        chk("rst_low_pkt",     {7'd0, low_pkt_valid}, 8'd0);
        chk("rst_err",         {7'd0, err},           8'd0);
        rst = 1'b1;

        // Good packet: header 0D, payload 11 22 33; 0D^11^22^33 = 0D.
        step(1,0,0,0,0,0,1,8'h0D,0, 8'h00);
        chk("good_pd_clear", {7'd0, parity_done}, 8'd0);
        step(0,1,0,0,0,0,1,8'h11,0, 8'h0D);
        step(0,0,1,0,0,0,1,8'h11,0, 8'h11);
        step(0,0,1,0,0,0,1,8'h22,0, 8'h22);
        step(0,0,1,0,0,0,1,8'h33,0, 8'h33);
        step(0,0,1,0,0,0,0,8'h0D,0, 8'h0D);
        chk("good_pd",  {7'd0, parity_done},   8'd1);
        chk("good_low", {7'd0, low_pkt_valid}, 8'd1);
        chk("good_err_early", {7'd0, err},     8'd0);
        step(0,0,0,0,0,0,0,8'h00,1, 8'h0D);
        chk("good_err",     {7'd0, err},           8'd0);
        chk("good_low_clr", {7'd0, low_pkt_valid}, 8'd0);
        chk("good_pd_hold", {7'd0, parity_done},   8'd1);

        // Bad parity: same packet, parity byte FF.
        step(1,0,0,0,0,0,1,8'h0D,0, 8'h0D);
        chk("bad_pd_clear", {7'd0, parity_done}, 8'd0);
        step(0,1,0,0,0,0,1,8'h11,0, 8'h0D);
        step(0,0,1,0,0,0,1,8'h11,0, 8'h11);
        step(0,0,1,0,0,0,1,8'h22,0, 8'h22);
        step(0,0,1,0,0,0,1,8'h33,0, 8'h33);
        step(0,0,1,0,0,0,0,8'hFF,0, 8'hFF);
        chk("bad_pd",       {7'd0, parity_done}, 8'd1);
        chk("bad_err_wait", {7'd0, err},         8'd0);
        step(0,0,0,0,0,0,0,8'h00,1, 8'hFF);
        chk("bad_err", {7'd0, err}, 8'd1);
        // New header clears err and parity_done; dout holds.
        step(1,0,0,0,0,0,1,8'h0D,0, 8'hFF);
        chk("bad_err_clr", {7'd0, err},         8'd0);
        chk("bad_pd_clr",  {7'd0, parity_done}, 8'd0);

        // FIFO full on payload 22, then again on the parity byte.
        step(0,1,0,0,0,0,1,8'h11,0, 8'h0D);
        step(0,0,1,0,0,0,1,8'h11,0, 8'h11);
        step(0,0,1,0,0,1,1,8'h22,0, 8'h11);
        step(0,0,0,0,1,1,1,8'h22,0, 8'h11);
        step(0,0,0,1,0,0,1,8'h22,0, 8'h22);
        chk("full_pd_not_yet", {7'd0, parity_done}, 8'd0);
        step(0,0,1,0,0,0,1,8'h33,0, 8'h33);
        step(0,0,1,0,0,1,0,8'h0D,0, 8'h33);
        chk("full_low",     {7'd0, low_pkt_valid}, 8'd1);
        chk("full_pd_wait", {7'd0, parity_done},   8'd0);
        step(0,0,0,0,1,1,0,8'h0D,0, 8'h33);
        step(0,0,0,1,0,0,0,8'h0D,0, 8'h0D);
        chk("full_pd", {7'd0, parity_done}, 8'd1);
        step(0,0,0,0,0,0,0,8'h00,1, 8'h0D);
        chk("full_err",     {7'd0, err},           8'd0);
        chk("full_low_clr", {7'd0, low_pkt_valid}, 8'd0);

        // Address 3 header is ignored; previous header 0D replays.
        step(1,0,0,0,0,0,1,8'h07,0, 8'h0D);
        step(0,1,0,0,0,0,1,8'h11,0, 8'h0D);
        step(0,0,1,0,0,0,1,8'h11,0, 8'h11);

        // Reset in the middle of LOAD_DATA.
        rst = 1'b0;
        step(0,0,1,0,0,0,1,8'h22,0, 8'h00);
        chk("mid_rst_pd",  {7'd0, parity_done},   8'd0);
        chk("mid_rst_low", {7'd0, low_pkt_valid}, 8'd0);
        chk("mid_rst_err", {7'd0, err},           8'd0);
        rst = 1'b1;

        // Clean packet after reset.
        step(1,0,0,0,0,0,1,8'h0D,0, 8'h00);
        step(0,1,0,0,0,0,1,8'h11,0, 8'h0D);
        step(0,0,1,0,0,0,1,8'h11,0, 8'h11);
        step(0,0,1,0,0,0,1,8'h22,0, 8'h22);
        step(0,0,1,0,0,0,1,8'h33,0, 8'h33);
        step(0,0,1,0,0,0,0,8'h0D,0, 8'h0D);
        chk("post_rst_pd", {7'd0, parity_done}, 8'd1);
        step(0,0,0,0,0,0,0,8'h00,1, 8'h0D);
        chk("post_rst_err", {7'd0, err}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
